// File: rtl/afifo_pkg.sv
// Shared helpers for the asynchronous FIFO write-side controller:
// Gray encode/decode and a constant log2 for sizing the arbiter index.
package afifo_pkg;

   function automatic logic [31:0] gray_enc(input logic [31:0] bin);
      return (bin >> 1) ^ bin;
   endfunction

   // Zero-extended inputs decode correctly because each binary bit is the XOR of the Gray bits above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << r) < n) begin
            r = r + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/afifo_wr_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last+1 (mod NREQ)
// and grants the first active requester when enabled.
module rr_arbiter
   import afifo_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int LW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [LW-1:0]   last,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [LW-1:0]   gnt_idx
);

   // rotating priority search starting just after the previous winner
   always_comb begin
      int  idx;
      logic found;
      gnt     = '0;
      gnt_idx = last;
      found   = 1'b0;
      idx     = 0;
      if (en) begin
         for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
               found        = 1'b1;
               gnt[idx]     = 1'b1;
               gnt_idx      = LW'(idx);
            end else begin
               found = found;
            end
         end
      end else begin
         gnt = '0;
      end
   end

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO: round-robin producer
// arbitration, binary/Gray write pointers, and registered full/level status.
module afifo_wr_ctrl
   import afifo_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int NREQ       = 4,
   parameter int AF_THRESH  = 6
) (
   input  logic                       wclk,
   input  logic                       wrst_n,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*DATA_WIDTH-1:0] req_data,
   input  logic [WIDTH-1:0]           wq2_rptr,
   output logic [NREQ-1:0]            gnt,
   output logic                       winc,
   output logic [DATA_WIDTH-1:0]      wdata,
   output logic [WIDTH-2:0]           waddr,
   output logic [WIDTH-1:0]           wptr,
   output logic                       wfull,
   output logic [WIDTH-1:0]           wlevel,
   output logic                       walmost_full
);

   localparam int LW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);

   logic [WIDTH-1:0] wbin_r;
   logic [LW-1:0]    last_r;
   logic [LW-1:0]    gnt_idx_s;
   logic [WIDTH-1:0] wbinnext_s;
   logic [WIDTH-1:0] wgraynext_s;
   logic [WIDTH-1:0] rbin_s;
   logic [WIDTH-1:0] level_next_s;
   logic [WIDTH-1:0] full_ptr_s;

   rr_arbiter #(
      .NREQ (NREQ),
      .LW   (LW)
   ) u_arb (
      .req     (req),
      .last    (last_r),
      .en      (~wfull),
      .gnt     (gnt),
      .gnt_idx (gnt_idx_s)
   );

   assign winc  = |gnt;
   assign waddr = wbin_r[WIDTH-2:0];

   // one-hot grant turns the AND-OR into a plain mux
   always_comb begin
      wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         wdata = wdata | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt[i]}});
      end
   end

   // next-pointer, full-compare and fill-level arithmetic
   always_comb begin
      wbinnext_s   = wbin_r + {{(WIDTH-1){1'b0}}, winc};
      wgraynext_s  = WIDTH'(gray_enc(32'(wbinnext_s)));
      rbin_s       = WIDTH'(gray2bin(32'(wq2_rptr)));
      level_next_s = wbinnext_s - rbin_s;
      full_ptr_s   = {~wq2_rptr[WIDTH-1:WIDTH-2], wq2_rptr[WIDTH-3:0]};
   end

   // pointer, arbitration history and status registers
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin_r       <= '0;
         wptr         <= '0;
         last_r       <= LW'(NREQ-1);
         wfull        <= 1'b0;
         wlevel       <= '0;
         walmost_full <= 1'b0;
      end else begin
         wbin_r       <= wbinnext_s;
         wptr         <= wgraynext_s;
         if (winc) begin
            last_r <= gnt_idx_s;
         end else begin
            last_r <= last_r;
         end
         wfull        <= (wgraynext_s == full_ptr_s);
         wlevel       <= level_next_s;
         walmost_full <= (level_next_s >= WIDTH'(AF_THRESH));
      end
   end

endmodule
